isr_check: RTL and testbench
============================

# isr_check

Sequential checker and squarer for integer-square-root results. Given a 64-bit radicand and a candidate 32-bit root, it computes root² with an iterative shift-add multiplier. It then reports whether the root is the exact floor square root, plus the remainder. It sits beside the square-root datapath as its consumer-side verifier and runs in the same clock domain.

## Interface
- BITS_PER_CYCLE, 1: multiplier bits retired per MULT cycle. Legal values are 1, 2 and 4. N = 32/BITS_PER_CYCLE.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- value  input  64  radicand; latched when start is accepted.
- root  input  32  candidate root; latched when start is accepted.
- busy  output  1  high in MULT and CHECK.
- done  output  1  high in DONE. Held until the next accepted start or reset.
- square  output  64  root², valid while done.
- remainder  output  64  value − root² when root² ≤ value, else 0. Valid while done.
- correct  output  1  1 iff root² ≤ value < (root+1)². Valid while done.

## Operation
- States: IDLE, MULT, CHECK, DONE.
- IDLE: start=1 latches value and root, clears the accumulator and iteration counter, then goes to MULT.
- MULT:
  - Each cycle adds root×(next BITS_PER_CYCLE multiplier bits, LSB first) into the 64-bit accumulator at the current shift.
  - Counter increments each cycle; after N cycles the FSM goes to CHECK.
- CHECK: one cycle.
  - Computes next_sq = acc + 2·root + 1 in 65 bits.
  - Computes correct = (acc ≤ value) && ({1'b0,value} < next_sq).
  - Computes remainder = (acc ≤ value) ? value − acc : 0.
  - Registers square, correct and remainder, then goes to DONE.
- DONE: outputs stay stable. start=1 behaves exactly as in IDLE: re-latches operands, done drops next cycle, FSM goes to MULT.
- start during MULT/CHECK is ignored. value/root changes during busy have no effect.
- Width rules:
  - root² never overflows 64 bits, since (2³²−1)² < 2⁶⁴.
  - (root+1)² reaches 2⁶⁴ at root = 2³²−1, so next_sq is 65 bits.
  - Remainder subtraction is 64-bit unsigned and only performed when non-negative.
- reset in any state:
  - Next state is IDLE.
  - Outputs return to reset values.
  - Any in-flight computation is discarded; no done is produced for it.

## Timing
- Reset values: busy=0, done=0, square=0, remainder=0, correct=0, state IDLE, counter 0.
- Start accepted at edge k. Then:
  - busy is high from k through k+N+1.
  - done is high from edge k+N+2.
  - Latency is N+2 cycles (34 for BITS_PER_CYCLE=1, 10 for 4).
- done and busy are never high simultaneously.
- Back-to-back: start held high in DONE restarts every N+2 cycles, with done high for exactly one cycle per result.
- Outputs change only at the CHECK→DONE edge or on reset.

## Structure
- Shared package isr_pkg:
  - state enum typedef for IDLE/MULT/CHECK/DONE.
  - ROOT_W=32, VALUE_W=64.
  - Iteration-count function of BITS_PER_CYCLE.
- Sub-module isr_shift_mult: iterative multiplier core (load, step, count, finished). isr_check owns the FSM, the compare/remainder logic and the output registers.
- Parameter check: elaboration error if BITS_PER_CYCLE ∉ {1,2,4}.

## Test plan
- value=17, root=4, BITS_PER_CYCLE=1 -> done at start edge+34, square=16, remainder=1, correct=1.
- value=16, root=4 -> square=16, remainder=0, correct=1. value=15, root=4 -> square=16, remainder=0, correct=0. value=25, root=4 -> correct=0, remainder=9.
- value=64'hFFFF_FFFF_FFFF_FFFF, root=32'hFFFF_FFFF -> square=64'hFFFF_FFFE_0000_0001, remainder=64'h1_FFFF_FFFE, correct=1 (checks 65-bit next_sq). Also value=0, root=0 -> square=0, correct=1.
- reset asserted 10 cycles after start -> busy=0 and state IDLE next cycle, done never rises. A following start then yields a correct result.
- start pulsed at cycles 5 and 20 of MULT, with root/value changed mid-run -> ignored, result reflects the operands latched at the original start. start held in DONE -> done drops next cycle, new result after N+2 cycles.
- Repeat the first and third scenarios with BITS_PER_CYCLE=2 and 4 -> identical results, latency 18 and 10 cycles respectively.

Source files
------------

// File: rtl/isr_pkg.sv
// Shared types and constants for the integer-square-root checker.
// The iteration count helper keeps the multiplier length tied to the digit width.
package isr_pkg;

    localparam int ROOT_W  = 32;
    localparam int VALUE_W = 64;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_CHECK,
        S_DONE
    } isr_state_t;

    function automatic int iter_count(input int bits_per_cycle);
        return ROOT_W / bits_per_cycle;
    endfunction

    function automatic bit bpc_legal(input int bits_per_cycle);
        return (bits_per_cycle == 1) || (bits_per_cycle == 2) || (bits_per_cycle == 4);
    endfunction

endpackage

// File: rtl/isr_shift_mult.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per step, LSB first.
// finished rises once all ROOT_W multiplier bits have been consumed and holds until the next load.
module isr_shift_mult
    import isr_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [ROOT_W-1:0]  multiplicand,
    input  logic [ROOT_W-1:0]  multiplier,
    output logic [VALUE_W-1:0] product,
    output logic               finished
);

    localparam int              N     = iter_count(BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    logic [VALUE_W-1:0] mcand_q;
    logic [VALUE_W-1:0] acc_q;
    logic [VALUE_W-1:0] partial;
    logic [ROOT_W-1:0]  mplier_q;
    logic [CNT_W-1:0]   count_q;

    // Partial product of the shifted multiplicand with the next multiplier digit.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (load) begin
            mcand_q  <= {{(VALUE_W-ROOT_W){1'b0}}, multiplicand};
            mplier_q <= multiplier;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (step && (count_q != N_CNT)) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            count_q  <= count_q + CNT_W'(1);
        end
    end

    assign product  = acc_q;
    assign finished = (count_q == N_CNT);

endmodule

// File: rtl/isr_check.sv
// Verifies a candidate floor square root: squares the root iteratively, then
// registers the square, the remainder and whether root is exactly floor(sqrt(value)).
module isr_check
    import isr_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    input  logic [ROOT_W-1:0]  root,
    output logic               busy,
    output logic               done,
    output logic [VALUE_W-1:0] square,
    output logic [VALUE_W-1:0] remainder,
    output logic               correct
);

    if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
        $error("isr_check: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    isr_state_t         state_q;
    isr_state_t         state_d;
    logic               load;
    logic               step;
    logic               mult_finished;
    logic [VALUE_W-1:0] acc;
    logic [VALUE_W-1:0] value_q;
    logic [ROOT_W-1:0]  root_q;

    logic [VALUE_W:0]   next_sq;
    logic               sq_fits;
    logic               correct_d;
    logic [VALUE_W-1:0] remainder_d;

    isr_shift_mult #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mult (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .step         (step),
        .multiplicand (root),
        .multiplier   (root),
        .product      (acc),
        .finished     (mult_finished)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE accepts a new start exactly like IDLE; MULT waits one cycle after the last step.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                if (mult_finished) begin
                    state_d = S_CHECK;
                end else begin
                    step = 1'b1;
                end
            end
            S_CHECK: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // (root+1)^2 reaches 2^64 for the largest root, hence the extra bit on next_sq.
    always_comb begin
        next_sq     = {1'b0, acc} + {{(VALUE_W-ROOT_W){1'b0}}, root_q, 1'b0} + (VALUE_W+1)'(1);
        sq_fits     = (acc <= value_q);
        correct_d   = sq_fits && ({1'b0, value_q} < next_sq);
        remainder_d = sq_fits ? (value_q - acc) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q   <= '0;
            root_q    <= '0;
            square    <= '0;
            remainder <= '0;
            correct   <= 1'b0;
        end else begin
            if (load) begin
                value_q <= value;
                root_q  <= root;
            end
            if (state_q == S_CHECK) begin
                square    <= acc;
                remainder <= remainder_d;
                correct   <= correct_d;
            end
        end
    end

    assign busy = (state_q == S_MULT) || (state_q == S_CHECK);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_isr_check.sv
// Scoreboard bench for isr_check: one DUT per legal BITS_PER_CYCLE, exercised lane by lane
// against a binary-search floor-sqrt reference model.
module tb_isr_check;

    localparam int LANES = 3;

    typedef struct {
        int          lane;
        logic [63:0] sq;
        logic [63:0] rem;
        logic        ok;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_w     [LANES];
    logic [63:0] value_w     [LANES];
    logic [31:0] root_w      [LANES];
    logic        busy_w      [LANES];
    logic        done_w      [LANES];
    logic [63:0] square_w    [LANES];
    logic [63:0] remainder_w [LANES];
    logic        correct_w   [LANES];
    logic        done_prev   [LANES];

    exp_t sb[$];
    exp_t e;
    int   edge_cnt = 0;
    int   n_total  = 0;
    int   n_pass   = 0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        isr_check #(
            .BITS_PER_CYCLE(1 << g)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start_w[g]),
            .value     (value_w[g]),
            .root      (root_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .square    (square_w[g]),
            .remainder (remainder_w[g]),
            .correct   (correct_w[g])
        );
    end

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lane_n(input int lane);
        return 32 / (1 << lane);
    endfunction

    // Floor square root by binary search over the 32-bit root range.
    function automatic logic [63:0] isqrt(input logic [63:0] v);
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] mid;
        lo = 64'd0;
        hi = 64'hFFFF_FFFF;
        while (lo < hi) begin
            mid = lo + (hi - lo + 64'd1) / 64'd2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 64'd1;
        end
        return lo;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic pushExp(input int lane, input logic [63:0] v, input logic [31:0] r, input int accept);
        exp_t x;
        logic [63:0] r64;
        r64   = {32'd0, r};
        x.lane = lane;
        x.sq   = r64 * r64;
        x.ok   = (r64 == isqrt(v));
        x.rem  = (x.sq <= v) ? (v - x.sq) : 64'd0;
        x.due  = accept + lane_n(lane) + 2;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input int lane, input logic [63:0] v, input logic [31:0] r, input bit expect_result);
        @(negedge clock);
        start_w[lane] = 1'b1;
        value_w[lane] = v;
        root_w[lane]  = r;
        @(posedge clock);
        #1;
        if (expect_result) pushExp(lane, v, r, edge_cnt);
        start_w[lane] = 1'b0;
        value_w[lane] = {$urandom, $urandom};
        root_w[lane]  = $urandom;
    endtask

    task automatic waitDone(input int lane);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done_w[lane] && n < 200);
        if (!done_w[lane]) checkOutput("done_timeout", {63'd0, done_w[lane]}, 64'd1);
    endtask

    // Monitor: every rising done pops the oldest expectation and compares it.
    always @(negedge clock) begin
        for (int l = 0; l < LANES; l++) begin
            if (done_w[l] && !done_prev[l]) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", {63'd0, done_w[l]}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("lane",      64'(l),                   64'(e.lane));
                    checkOutput("square",    square_w[l],              e.sq);
                    checkOutput("remainder", remainder_w[l],           e.rem);
                    checkOutput("correct",   {63'd0, correct_w[l]},    {63'd0, e.ok});
                    checkOutput("latency",   64'(edge_cnt),            64'(e.due));
                    checkOutput("busy_with_done", {63'd0, busy_w[l]},  64'd0);
                end
            end
            done_prev[l] = done_w[l];
        end
    end

    task automatic runLane(input int lane);
        int          n;
        int          hold;
        logic [63:0] v;
        logic [63:0] r64;
        logic [31:0] r;
        n = lane_n(lane);
        $display("[TB] lane %0d, BITS_PER_CYCLE=%0d", lane, 1 << lane);

        applyStimulus(lane, 64'd17, 32'd4, 1'b1); waitDone(lane);
        applyStimulus(lane, 64'd16, 32'd4, 1'b1); waitDone(lane);
        applyStimulus(lane, 64'd15, 32'd4, 1'b1); waitDone(lane);
        applyStimulus(lane, 64'd25, 32'd4, 1'b1); waitDone(lane);
        applyStimulus(lane, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1); waitDone(lane);
        applyStimulus(lane, 64'd0, 32'd0, 1'b1); waitDone(lane);

        // Start pulses and operand changes while busy must be ignored.
        applyStimulus(lane, 64'd1_000_000, 32'd1000, 1'b1);
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            start_w[lane] = (c == 5) || (c == 20);
            value_w[lane] = {$urandom, $urandom};
            root_w[lane]  = $urandom;
        end
        @(negedge clock);
        start_w[lane] = 1'b0;
        waitDone(lane);

        // Start held in DONE restarts immediately; done lasts one cycle.
        @(negedge clock);
        start_w[lane] = 1'b1;
        value_w[lane] = 64'd99;
        root_w[lane]  = 32'd9;
        @(posedge clock);
        #1;
        pushExp(lane, 64'd99, 32'd9, edge_cnt);
        value_w[lane] = 64'd100;
        root_w[lane]  = 32'd10;
        waitDone(lane);
        @(posedge clock);
        #1;
        pushExp(lane, 64'd100, 32'd10, edge_cnt);
        checkOutput("b2b_done_drop", {63'd0, done_w[lane]}, 64'd0);
        start_w[lane] = 1'b0;
        waitDone(lane);

        // Reset mid-run discards the computation and clears the outputs.
        hold = (n / 2 < 10) ? n / 2 : 10;
        applyStimulus(lane, 64'd50, 32'd7, 1'b0);
        repeat (hold) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("reset_busy",   {63'd0, busy_w[lane]},    64'd0);
        checkOutput("reset_done",   {63'd0, done_w[lane]},    64'd0);
        checkOutput("reset_square", square_w[lane],           64'd0);
        checkOutput("reset_rem",    remainder_w[lane],        64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (n + 8) @(negedge clock);
        applyStimulus(lane, 64'd50, 32'd7, 1'b1); waitDone(lane);

        for (int t = 0; t < 6; t++) begin
            v = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 5000));
            r64 = isqrt(v);
            case ($urandom_range(0, 3))
                0: r = r64[31:0];
                1: r = r64[31:0] + 32'd1;
                2: r = (r64 != 64'd0) ? r64[31:0] - 32'd1 : 32'd0;
                default: r = $urandom;
            endcase
            applyStimulus(lane, v, r, 1'b1);
            waitDone(lane);
        end
    endtask

    initial begin
        for (int l = 0; l < LANES; l++) begin
            start_w[l]   = 1'b0;
            value_w[l]   = 64'd0;
            root_w[l]    = 32'd0;
            done_prev[l] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int l = 0; l < LANES; l++) begin
            checkOutput("init_busy",    {63'd0, busy_w[l]},    64'd0);
            checkOutput("init_done",    {63'd0, done_w[l]},    64'd0);
            checkOutput("init_square",  square_w[l],           64'd0);
            checkOutput("init_rem",     remainder_w[l],        64'd0);
            checkOutput("init_correct", {63'd0, correct_w[l]}, 64'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int l = 0; l < LANES; l++) runLane(l);

        repeat (5) @(negedge clock);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
